stage2: RTL and testbench
=========================

Name: stage2

Overview:
- Second pipeline stage of the CPU datapath.
- Resolves the read-write operand (vrw) from RAM, an immediate or the PC, according to the addressing mode `mblock_s2`.
- Drives the RAM read address and runs the ALU on vrw and the read operand vr, producing the write-back value vw and a zero flag.
- Combinational results feed stage 3 directly; a registered copy of the ALU result and flag is also provided.

Parameters:
- None. All widths are fixed: data 32, address/PC 16, source fields 8, mode 3, ALU op 4.

Ports:
- clk  in  1  stage clock (rising edge)
- reset  in  1  asynchronous, active-high reset
- mblock_s2  in  3  operand addressing mode
- vr_source  in  8  vr source field (high byte of the 16-bit address/immediate)
- vr_value  in  32  already-resolved vr operand value
- vrw_source  in  8  vrw source field (low byte of the address/immediate)
- alu_op  in  4  ALU operation select
- pc  in  16  current program counter
- ram_value  in  32  RAM read data for ram_address (combinational RAM)
- vrw_value  out  32  resolved vrw operand
- vw_value  out  32  ALU result (combinational)
- ram_address  out  16  RAM read address
- alu_is_zero  out  1  1 when vw_value == 0 (combinational)
- vw_value_q  out  32  vw_value registered on clk
- alu_is_zero_q  out  1  alu_is_zero registered on clk

Behaviour:
- vrw_value, vw_value, ram_address and alu_is_zero are purely combinational, with zero latency and no dependence on clk or reset.

Addressing mode `mblock_s2` (zero-extension throughout):
- 0: ram_address = {8'h00, vrw_source}; vrw_value = ram_value
- 1: ram_address = vr_value[15:0]; vrw_value = ram_value
- 2: ram_address = {vr_source, vrw_source}; vrw_value = ram_value
- 3: reserved; behaves exactly as mode 0
- 4: vrw_value = {24'h0, vrw_source}; ram_address = {8'h00, vrw_source}
- 5: reserved; behaves exactly as mode 4
- 6: vrw_value = {16'h0, vr_source, vrw_source}; ram_address = {vr_source, vrw_source}
- 7: vrw_value = {16'h0, pc}; ram_address = {8'h00, vrw_source}
- X/Z on mblock_s2: outputs are don't-care.

ALU, with A = vrw_value and B = vr_value; all results are 32-bit with wrap-around and no carry-out:
- 0: A + B
- 1: A - B (two's complement; 0 - 1 = 32'hFFFFFFFF)
- 2: A & B
- 3: A | B
- 4: A ^ B
- 5: A << B[4:0]
- 6: A >> B[4:0] (logical)
- 7: B (move)
- 8-15: 32'h0

Zero flag:
- alu_is_zero = (vw_value == 32'h0). Undefined ALU ops therefore report zero = 1.

Registered outputs:
- On reset = 1, asynchronously: vw_value_q = 0 and alu_is_zero_q = 0. They remain 0 while reset is held.
- Reset deasserted: every rising clk edge captures vw_value_q <= vw_value and alu_is_zero_q <= alu_is_zero. Latency is 1 cycle.
- Reset asserted mid-operation clears both registers immediately. The combinational outputs are unaffected by reset.

Test Plan:
- Shared setup: vr_source=10, vr_value=1000, vrw_source=20, alu_op=0, pc=84, ram_value=99.
  - Mode 0 -> ram_address=20, vrw_value=99, vw_value=1099, alu_is_zero=0.
  - Mode 1 -> ram_address=1000, vrw_value=99, vw_value=1099.
  - Mode 2 -> ram_address=2580 ((10<<8)|20), vrw_value=99, vw_value=1099.
- Same setup, immediate and PC modes:
  - Mode 4 -> vrw_value=20, vw_value=1020.
  - Mode 6 -> vrw_value=2580, vw_value=3580.
  - Mode 7 -> vrw_value=84, vw_value=1084. All with alu_is_zero=0.
- Mode 0, alu_op=1, ram_value=1000, vr_value=1000 -> vrw_value=1000, ram_address=20, vw_value=0, alu_is_zero=1.
- Wrap and ops:
  - Mode 4, vrw_source=0, vr_value=1, alu_op=1 -> vw_value=32'hFFFFFFFF, alu_is_zero=0.
  - alu_op=0 with A=32'hFFFFFFFF (mode 1, ram_value=32'hFFFFFFFF), B=1 -> vw_value=0, alu_is_zero=1.
  - alu_op 2..7 with A=32'hF0, B=4 -> 0, 32'hF4, 32'hF4, 32'hF00, 32'hF, 4.
- Registered path:
  - reset=1 -> vw_value_q=0, alu_is_zero_q=0 with no clock edge.
  - Release reset with vw_value=1099, one clk edge -> vw_value_q=1099, alu_is_zero_q=0.
  - Assert reset between edges -> both clear at once.
- Reserved modes: mode 3 matches mode 0 outputs and mode 5 matches mode 4 outputs for identical inputs; alu_op=12 -> vw_value=0, alu_is_zero=1.

Source files
------------

// File: rtl/stage2_if.sv
// Operand/ALU bus between the stage-2 datapath and its surroundings.
// master drives the operand fields and RAM read data; slave (stage2) returns
// the resolved operand, RAM address, ALU result and zero flag.
interface stage2_if;
    logic [2:0]  mblock_s2;
    logic [7:0]  vr_source;
    logic [31:0] vr_value;
    logic [7:0]  vrw_source;
    logic [3:0]  alu_op;
    logic [15:0] pc;
    logic [31:0] ram_value;
    logic [31:0] vrw_value;
    logic [31:0] vw_value;
    logic [15:0] ram_address;
    logic        alu_is_zero;
    logic [31:0] vw_value_q;
    logic        alu_is_zero_q;

    modport master (
        output mblock_s2, vr_source, vr_value, vrw_source, alu_op, pc, ram_value,
        input  vrw_value, vw_value, ram_address, alu_is_zero, vw_value_q, alu_is_zero_q
    );

    modport slave (
        input  mblock_s2, vr_source, vr_value, vrw_source, alu_op, pc, ram_value,
        output vrw_value, vw_value, ram_address, alu_is_zero, vw_value_q, alu_is_zero_q
    );
endinterface

// File: rtl/stage2.sv
// Second pipeline stage: resolves the read-write operand from RAM, an
// immediate or the PC, drives the RAM read address, runs the ALU and
// provides both a combinational and a registered copy of the result.
module stage2 (
    input  logic     clk,
    input  logic     reset,
    stage2_if.slave  bus
);

    logic [15:0] ram_address;
    logic [31:0] vrw_value;
    logic [31:0] vw_value;
    logic        alu_is_zero;
    logic [31:0] vw_value_q;
    logic        alu_is_zero_q;

    // Operand resolution: pick RAM address and vrw source from the addressing mode.
    always_comb begin
        ram_address = {8'h00, bus.vrw_source};
        vrw_value   = bus.ram_value;
        case (bus.mblock_s2)
            3'd0, 3'd3: begin
                ram_address = {8'h00, bus.vrw_source};
                vrw_value   = bus.ram_value;
            end
            3'd1: begin
                ram_address = bus.vr_value[15:0];
                vrw_value   = bus.ram_value;
            end
            3'd2: begin
                ram_address = {bus.vr_source, bus.vrw_source};
                vrw_value   = bus.ram_value;
            end
            3'd4, 3'd5: begin
                ram_address = {8'h00, bus.vrw_source};
                vrw_value   = {24'h000000, bus.vrw_source};
            end
            3'd6: begin
                ram_address = {bus.vr_source, bus.vrw_source};
                vrw_value   = {16'h0000, bus.vr_source, bus.vrw_source};
            end
            3'd7: begin
                ram_address = {8'h00, bus.vrw_source};
                vrw_value   = {16'h0000, bus.pc};
            end
            default: begin
                ram_address = {8'h00, bus.vrw_source};
                vrw_value   = bus.ram_value;
            end
        endcase
    end

    // ALU: A = resolved vrw operand, B = vr operand; undefined ops yield zero.
    always_comb begin
        vw_value = 32'h0000_0000;
        case (bus.alu_op)
            4'd0:    vw_value = vrw_value + bus.vr_value;
            4'd1:    vw_value = vrw_value - bus.vr_value;
            4'd2:    vw_value = vrw_value & bus.vr_value;
            4'd3:    vw_value = vrw_value | bus.vr_value;
            4'd4:    vw_value = vrw_value ^ bus.vr_value;
            4'd5:    vw_value = vrw_value << bus.vr_value[4:0];
            4'd6:    vw_value = vrw_value >> bus.vr_value[4:0];
            4'd7:    vw_value = bus.vr_value;
            default: vw_value = 32'h0000_0000;
        endcase
        alu_is_zero = (vw_value == 32'h0000_0000);
    end

    // Registered copy of the ALU result and flag, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vw_value_q    <= 32'h0000_0000;
            alu_is_zero_q <= 1'b0;
        end else begin
            vw_value_q    <= vw_value;
            alu_is_zero_q <= alu_is_zero;
        end
    end

    assign bus.ram_address   = ram_address;
    assign bus.vrw_value     = vrw_value;
    assign bus.vw_value      = vw_value;
    assign bus.alu_is_zero   = alu_is_zero;
    assign bus.vw_value_q    = vw_value_q;
    assign bus.alu_is_zero_q = alu_is_zero_q;

endmodule

// File: tb/tb_stage2.sv
// Self-checking bench for stage2: directed cases from the datapath rules,
// the registered/reset path, then randomized vectors against a reference model.
module tb_stage2;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    stage2_if bus ();

    stage2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] m, input logic [7:0] vs, input logic [31:0] vv,
                          input logic [7:0] ws, input logic [3:0] op, input logic [15:0] p,
                          input logic [31:0] rv);
        bus.mblock_s2  = m;
        bus.vr_source  = vs;
        bus.vr_value   = vv;
        bus.vrw_source = ws;
        bus.alu_op     = op;
        bus.pc         = p;
        bus.ram_value  = rv;
    endtask

    // Reference model straight from the addressing/ALU rules.
    task automatic ref_model(input logic [2:0] m, input logic [7:0] vs, input logic [31:0] vv,
                             input logic [7:0] ws, input logic [3:0] op, input logic [15:0] p,
                             input logic [31:0] rv,
                             output logic [15:0] addr, output logic [31:0] a,
                             output logic [31:0] res, output logic zero);
        logic [31:0] r [0:7];
        logic [15:0] imm16;
        imm16 = {vs, ws};
        if (m == 3'd1)                    addr = vv[15:0];
        else if (m == 3'd2 || m == 3'd6)  addr = imm16;
        else                              addr = {8'h00, ws};
        if (m <= 3'd3)       a = rv;
        else if (m == 3'd7)  a = {16'h0000, p};
        else if (m == 3'd6)  a = {16'h0000, imm16};
        else                 a = {24'h000000, ws};
        r[0] = a + vv;
        r[1] = a + (~vv + 32'd1);
        r[2] = a & vv;
        r[3] = a | vv;
        r[4] = a ^ vv;
        r[5] = a * (32'd1 << vv[4:0]);
        r[6] = a / (32'd1 << vv[4:0]);
        r[7] = vv;
        res  = (op < 4'd8) ? r[op[2:0]] : 32'h0000_0000;
        zero = (res == 32'h0000_0000);
    endtask

    logic [15:0] e_addr;
    logic [31:0] e_a;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] ops_exp [0:5];

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        set_in(3'd0, 8'd10, 32'd1000, 8'd20, 4'd0, 16'd84, 32'd99);

        // Reset state before any clock edge.
        #1;
        check_val("rst_vw_q", bus.vw_value_q, 32'd0);
        check_val("rst_zero_q", {31'd0, bus.alu_is_zero_q}, 32'd0);
        check_val("rst_comb_vw", bus.vw_value, 32'd1099);

        // Register modes.
        check_val("m0_addr", {16'd0, bus.ram_address}, 32'd20);
        check_val("m0_vrw", bus.vrw_value, 32'd99);
        check_val("m0_zero", {31'd0, bus.alu_is_zero}, 32'd0);
        bus.mblock_s2 = 3'd1; #1;
        check_val("m1_addr", {16'd0, bus.ram_address}, 32'd1000);
        check_val("m1_vw", bus.vw_value, 32'd1099);
        bus.mblock_s2 = 3'd2; #1;
        check_val("m2_addr", {16'd0, bus.ram_address}, 32'd2580);
        check_val("m2_vw", bus.vw_value, 32'd1099);
        bus.mblock_s2 = 3'd3; #1;
        check_val("m3_addr", {16'd0, bus.ram_address}, 32'd20);
        check_val("m3_vrw", bus.vrw_value, 32'd99);
        bus.mblock_s2 = 3'd4; #1;
        check_val("m4_vrw", bus.vrw_value, 32'd20);
        check_val("m4_vw", bus.vw_value, 32'd1020);
        bus.mblock_s2 = 3'd5; #1;
        check_val("m5_vrw", bus.vrw_value, 32'd20);
        check_val("m5_addr", {16'd0, bus.ram_address}, 32'd20);
        bus.mblock_s2 = 3'd6; #1;
        check_val("m6_vrw", bus.vrw_value, 32'd2580);
        check_val("m6_vw", bus.vw_value, 32'd3580);
        bus.mblock_s2 = 3'd7; #1;
        check_val("m7_vrw", bus.vrw_value, 32'd84);
        check_val("m7_vw", bus.vw_value, 32'd1084);
        check_val("m7_zero", {31'd0, bus.alu_is_zero}, 32'd0);

        // Subtraction to zero and wrap cases.
        set_in(3'd0, 8'd10, 32'd1000, 8'd20, 4'd1, 16'd84, 32'd1000); #1;
        check_val("sub0_vw", bus.vw_value, 32'd0);
        check_val("sub0_zero", {31'd0, bus.alu_is_zero}, 32'd1);
        set_in(3'd4, 8'd0, 32'd1, 8'd0, 4'd1, 16'd84, 32'd99); #1;
        check_val("subwrap_vw", bus.vw_value, 32'hFFFF_FFFF);
        check_val("subwrap_zero", {31'd0, bus.alu_is_zero}, 32'd0);
        set_in(3'd1, 8'd0, 32'd1, 8'd0, 4'd0, 16'd84, 32'hFFFF_FFFF); #1;
        check_val("addwrap_vw", bus.vw_value, 32'd0);
        check_val("addwrap_zero", {31'd0, bus.alu_is_zero}, 32'd1);

        // Logic/shift/move ops with A=0xF0, B=4.
        ops_exp[0] = 32'h0; ops_exp[1] = 32'hF4; ops_exp[2] = 32'hF4;
        ops_exp[3] = 32'hF00; ops_exp[4] = 32'hF; ops_exp[5] = 32'h4;
        for (int i = 0; i < 6; i++) begin
            set_in(3'd4, 8'd0, 32'd4, 8'hF0, 4'(i + 2), 16'd0, 32'd0); #1;
            check_val($sformatf("op%0d_vw", i + 2), bus.vw_value, ops_exp[i]);
        end
        set_in(3'd0, 8'd10, 32'd1000, 8'd20, 4'd12, 16'd84, 32'd99); #1;
        check_val("op12_vw", bus.vw_value, 32'd0);
        check_val("op12_zero", {31'd0, bus.alu_is_zero}, 32'd1);

        // Registered path: release reset, one edge, then async clear mid-cycle.
        set_in(3'd0, 8'd10, 32'd1000, 8'd20, 4'd0, 16'd84, 32'd99);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("reg_vw_q", bus.vw_value_q, 32'd1099);
        check_val("reg_zero_q", {31'd0, bus.alu_is_zero_q}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_vw_q", bus.vw_value_q, 32'd0);
        check_val("async_zero_q", {31'd0, bus.alu_is_zero_q}, 32'd0);
        check_val("async_comb_vw", bus.vw_value, 32'd1099);
        @(negedge clk);
        reset = 1'b0;

        // Randomized vectors against the reference model, including registered copy.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            set_in(3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom),
                   8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 32'($urandom));
            if ($urandom_range(0, 7) == 0) bus.vr_value = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) bus.ram_value = bus.vr_value;
            ref_model(bus.mblock_s2, bus.vr_source, bus.vr_value, bus.vrw_source,
                      bus.alu_op, bus.pc, bus.ram_value, e_addr, e_a, e_res, e_zero);
            #1;
            check_val("rnd_addr", {16'd0, bus.ram_address}, {16'd0, e_addr});
            check_val("rnd_vrw", bus.vrw_value, e_a);
            check_val("rnd_vw", bus.vw_value, e_res);
            check_val("rnd_zero", {31'd0, bus.alu_is_zero}, {31'd0, e_zero});
            @(posedge clk); #1;
            check_val("rnd_vw_q", bus.vw_value_q, e_res);
            check_val("rnd_zero_q", {31'd0, bus.alu_is_zero_q}, {31'd0, e_zero});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
